// File: rtl/timer_pkg.sv
// Shared types and default sizing for the countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } timer_state_t;

  localparam int DEF_NUM_BITS = 8;
  localparam int DEF_PRESCALE = 4;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits one tick every PRESCALE enabled cycles; holds while en is low.
module tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (restart)  cnt_d = '0;
    else if (en)  cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause, clear and auto-reload.
// Define TIMER_PRESCALE_EN to tick once per PRESCALE cycles instead of every cycle.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int NUM_BITS = DEF_NUM_BITS,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [NUM_BITS-1:0] load_value,
  input  logic                start,
  input  logic                pause,
  input  logic                clear,
  input  logic                auto_reload,
  output logic [NUM_BITS-1:0] count,
  output logic                at_zero,
  output logic                done,
  output logic                busy
);

  if (PRESCALE < 2 || PRESCALE > 65535) begin : g_bad_prescale
    $error("countdown_timer: PRESCALE must be within 2..65535");
  end

  timer_state_t        state_q, state_d;
  logic [NUM_BITS-1:0] count_q, count_d;
  logic [NUM_BITS-1:0] reload_q, reload_d;
  logic                done_q, done_d;
  logic                tick;

`ifdef TIMER_PRESCALE_EN
  logic tick_en, restart;
  // Prescaler phase restarts on a fresh run but survives a pause/resume.
  assign restart = clear ||
                   (state_d == ST_RUN && (state_q == ST_IDLE || state_q == ST_DONE));
  assign tick_en = (state_q == ST_RUN) && !clear && !pause;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .en      (tick_en),
    .restart (restart),
    .tick    (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (clear) begin
      count_d = '0;
      state_d = ST_IDLE;
    end else if (load && state_q != ST_RUN) begin
      count_d  = load_value;
      reload_d = load_value;
    end else if (pause) begin
      if (state_q == ST_RUN) state_d = ST_PAUSED;
    end else if (start && state_q == ST_PAUSED) begin
      state_d = ST_RUN;
    end else if (start && (state_q == ST_IDLE || state_q == ST_DONE) && count_q != '0) begin
      state_d = ST_RUN;
    end else if (state_q == ST_RUN && tick) begin
      if (count_q <= NUM_BITS'(1)) begin
        done_d = 1'b1;
        if (auto_reload && reload_q > NUM_BITS'(1)) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = ST_DONE;
        end
      end else begin
        count_d = count_q - NUM_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign count   = count_q;
  assign at_zero = (count_q == '0);
  assign done    = done_q;
  assign busy    = (state_q == ST_RUN) || (state_q == ST_PAUSED);

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter NUM_BITS, default 8, giving the counter width.
REQ-002 SHALL have parameter PRESCALE, default 4, giving the clock cycles per tick (used only when TIMER_PRESCALE_EN is defined); legal range 2 to 65535.
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 load  input  1  capture load_value into count and reload register.
REQ-006 load_value  input  NUM_BITS  value to load.
REQ-007 start  input  1  begin or resume counting.
REQ-008 pause  input  1  freeze counting.
REQ-009 clear  input  1  abort and zero the counter.
REQ-010 auto_reload  input  1  restart from the reload register on terminal count.
REQ-011 count  output  NUM_BITS  current counter value (registered).
REQ-012 at_zero  output  1  high when count equals 0 (combinational from count).
REQ-013 done  output  1  one-cycle pulse on terminal count (registered).
REQ-014 busy  output  1  high in RUN or PAUSED.

Function
REQ-015 SHALL implement states IDLE, RUN, PAUSED and DONE.
REQ-016 Control priority SHALL be rst > clear > load > pause > start.
REQ-017 clear in any state SHALL set count=0 and state=IDLE at the next edge; reload register is kept.
REQ-018 load in IDLE, PAUSED or DONE SHALL set count and reload register to load_value at the next edge, with no state change.
REQ-019 load in RUN SHALL be ignored.
REQ-020 start in IDLE or DONE with count!=0 SHALL enter RUN; with count==0 it SHALL be ignored.
REQ-021 start in PAUSED SHALL return to RUN.
REQ-022 pause in RUN SHALL enter PAUSED with count held.
REQ-023 pause and start asserted together in RUN SHALL pause.
REQ-024 In RUN, each tick SHALL decrement count by 1.
REQ-025 Without the prescaler, every cycle in RUN is a tick, so the first decrement occurs one edge after the edge that entered RUN.
REQ-026 A tick with count==1 and auto_reload=0 SHALL set count=0, enter DONE, and assert done for the next cycle only.
REQ-027 A tick with count==1 and auto_reload=1 and reload register >1 SHALL set count to the reload register, stay in RUN, and assert done for one cycle.
REQ-028 If the reload register is <=1 under REQ-027, the behaviour SHALL be per REQ-026 (count=0, DONE).
REQ-029 Count SHALL never wrap below 0; count SHALL not change in IDLE, PAUSED or DONE except via load or clear.
REQ-030 done SHALL be low in every cycle not specified by REQ-026 or REQ-027.
REQ-031 clear coincident with terminal count SHALL suppress done.

Reset
REQ-032 rst SHALL give count=0, reload register=0, state=IDLE, done=0, busy=0, at_zero=1, prescaler=0.
REQ-033 rst mid-count SHALL abort with no done pulse.

Configuration
REQ-034 With TIMER_PRESCALE_EN defined, a tick SHALL occur once per PRESCALE cycles while in RUN.
REQ-035 Under TIMER_PRESCALE_EN, the prescaler SHALL hold in PAUSED and SHALL zero on entering RUN from IDLE/DONE, on clear, and on rst.
REQ-036 Without TIMER_PRESCALE_EN, every RUN cycle SHALL be a tick and no prescaler logic SHALL exist.

Structure
REQ-037 Package timer_pkg SHALL hold the state enum typedef (timer_state_t) and the default NUM_BITS/PRESCALE constants.
REQ-038 The prescaler SHALL be sub-module tick_gen (inputs clk, rst, en, restart; output tick), instantiated only under TIMER_PRESCALE_EN.

Verification
REQ-039 Reset: rst high 2 cycles -> count=0, at_zero=1, done=0, busy=0.
REQ-040 One-shot: load 5, then start -> count 4,3,2,1,0 on successive cycles; done high exactly one cycle; state DONE; busy=0.
REQ-041 Auto-reload: auto_reload=1, load 3, start -> count 2,1,3,2,1,3...; done pulses every 3 cycles; count never 0.
REQ-042 Pause: pause at count 7, hold 4 cycles -> count stays 7; start -> 6 on the next tick.
REQ-043 Abort and ignore: load 9 during RUN -> ignored; clear at count 2 -> count=0, IDLE, no done; start at count 0 -> ignored.
REQ-044 Width and prescale: NUM_BITS=4, load 15 -> done after 15 ticks; with TIMER_PRESCALE_EN and PRESCALE=4 -> decrements every 4 cycles, 60 cycles total.
